// File: rtl/sata_fis_inserter.sv
`default_nettype none
//==============================================================================
// Module   : sata_fis_inserter
// Purpose  : SATA link-layer transmit framer: wraps a FIS dword stream in
//            SOF/EOF, fills idle time with SYNC, answers HOLD with HOLDA and
//            pads starvation with HOLD. Optional ALIGN insertion is enabled by
//            defining SATA_FIS_INSERTER_ALIGN_EN.
// Revision : 1.0  initial release
//==============================================================================

`ifndef SOF_PRIM
`define SOF_PRIM      32'h3737B57C
`endif
`ifndef EOF_PRIM
`define EOF_PRIM      32'hD5D5B57C
`endif
`ifndef SYNC_PRIM
`define SYNC_PRIM     32'hB5B5957C
`endif
`ifndef HOLD_PRIM
`define HOLD_PRIM     32'hD5D5AA7C
`endif
`ifndef HOLDA_PRIM
`define HOLDA_PRIM    32'h9595AA7C
`endif
`ifndef ALIGN_PRIM
`define ALIGN_PRIM    32'h7B4A4ABC
`endif
`ifndef DWORD_IS_PRIM
`define DWORD_IS_PRIM 1'b1
`endif
`ifndef DWORD_IS_DATA
`define DWORD_IS_DATA 1'b0
`endif

module sata_fis_inserter #(
  parameter int MIN_SYNC     = 2,
  parameter int ALIGN_PERIOD = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fis_dat,
  input  logic        fis_val,
  input  logic        fis_eop,
  output logic        fis_rdy,
  input  logic        hold_req,
  output logic [31:0] tx_data,
  output logic        tx_datak
);

  localparam int GAP_W = (MIN_SYNC < 2) ? 1 : $clog2(MIN_SYNC + 1);
  localparam logic [GAP_W-1:0] C_GAP_INIT = GAP_W'(MIN_SYNC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_EOF  = 2'd2
  } state_t;

  state_t             r_state;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [31:0]        r_tx_data;
  logic               r_tx_datak;
  logic               w_align_due;

`ifdef SATA_FIS_INSERTER_ALIGN_EN
  localparam int ACW = $clog2(ALIGN_PERIOD);
  localparam logic [ACW-1:0] C_ALIGN_LAST = ACW'(ALIGN_PERIOD - 1);

  logic [ACW-1:0]     r_align_cnt;
  logic               r_align_due;
  logic               r_align_second;

  assign w_align_due = r_align_due;
`else
  assign w_align_due = 1'b0;
`endif

  assign fis_rdy  = (r_state == ST_DATA) & ~hold_req & ~w_align_due;
  assign tx_data  = r_tx_data;
  assign tx_datak = r_tx_datak;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_gap_cnt  <= '0;
      r_tx_data  <= `SYNC_PRIM;
      r_tx_datak <= `DWORD_IS_PRIM;
`ifdef SATA_FIS_INSERTER_ALIGN_EN
      r_align_cnt    <= '0;
      r_align_due    <= 1'b0;
      r_align_second <= 1'b0;
`endif
    end else if (w_align_due) begin
      // Framing is frozen while the ALIGN pair goes out.
      r_tx_data  <= `ALIGN_PRIM;
      r_tx_datak <= `DWORD_IS_PRIM;
`ifdef SATA_FIS_INSERTER_ALIGN_EN
      r_align_second <= ~r_align_second;
      if (r_align_second) begin
        r_align_due <= 1'b0;
      end
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx_datak <= `DWORD_IS_PRIM;
          if (r_gap_cnt != '0) begin
            r_tx_data <= `SYNC_PRIM;
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end else if (fis_val) begin
            r_tx_data <= `SOF_PRIM;
            r_state   <= ST_DATA;
          end else begin
            r_tx_data <= `SYNC_PRIM;
          end
        end
        ST_DATA: begin
          if (hold_req) begin
            r_tx_data  <= `HOLDA_PRIM;
            r_tx_datak <= `DWORD_IS_PRIM;
          end else if (fis_val) begin
            r_tx_data  <= fis_dat;
            r_tx_datak <= `DWORD_IS_DATA;
            if (fis_eop) begin
              r_state <= ST_EOF;
            end
          end else begin
            r_tx_data  <= `HOLD_PRIM;
            r_tx_datak <= `DWORD_IS_PRIM;
          end
        end
        ST_EOF: begin
          r_tx_data  <= `EOF_PRIM;
          r_tx_datak <= `DWORD_IS_PRIM;
          r_gap_cnt  <= C_GAP_INIT;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_tx_data  <= `SYNC_PRIM;
          r_tx_datak <= `DWORD_IS_PRIM;
          r_state    <= ST_IDLE;
        end
      endcase
`ifdef SATA_FIS_INSERTER_ALIGN_EN
      // Every non-ALIGN load advances the period counter.
      if (r_align_cnt == C_ALIGN_LAST) begin
        r_align_cnt <= '0;
        r_align_due <= 1'b1;
      end else begin
        r_align_cnt <= r_align_cnt + ACW'(1);
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sata_fis_inserter.sv
`default_nettype none
//==============================================================================
// Module   : tb_sata_fis_inserter
// Purpose  : Self-checking bench for sata_fis_inserter (directed table, hand
//            sequences and randomized traffic against a stream-level model).
// Revision : 1.0  initial release
//==============================================================================

`ifndef SOF_PRIM
`define SOF_PRIM      32'h3737B57C
`endif
`ifndef EOF_PRIM
`define EOF_PRIM      32'hD5D5B57C
`endif
`ifndef SYNC_PRIM
`define SYNC_PRIM     32'hB5B5957C
`endif
`ifndef HOLD_PRIM
`define HOLD_PRIM     32'hD5D5AA7C
`endif
`ifndef HOLDA_PRIM
`define HOLDA_PRIM    32'h9595AA7C
`endif
`ifndef ALIGN_PRIM
`define ALIGN_PRIM    32'h7B4A4ABC
`endif
`ifndef DWORD_IS_PRIM
`define DWORD_IS_PRIM 1'b1
`endif
`ifndef DWORD_IS_DATA
`define DWORD_IS_DATA 1'b0
`endif

module tb_sata_fis_inserter;

  localparam int MIN_SYNC     = 2;
  localparam int ALIGN_PERIOD = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fis_dat;
  logic        fis_val;
  logic        fis_eop;
  logic        fis_rdy;
  logic        hold_req;
  logic [31:0] tx_data;
  logic        tx_datak;

  always #5 clk = ~clk;

  sata_fis_inserter #(
    .MIN_SYNC     (MIN_SYNC),
    .ALIGN_PERIOD (ALIGN_PERIOD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .fis_dat  (fis_dat),
    .fis_val  (fis_val),
    .fis_eop  (fis_eop),
    .fis_rdy  (fis_rdy),
    .hold_req (hold_req),
    .tx_data  (tx_data),
    .tx_datak (tx_datak)
  );

  typedef struct {
    logic        val;
    logic        eop;
    logic        hold;
    logic [31:0] dat;
    logic        exp_rdy;
    logic [31:0] exp_tx;
    logic        exp_k;
  } vec_t;

  vec_t        tbl[$];
  logic [32:0] src_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;

  // Stream-level model of the link: where we are in the frame, SYNCs still
  // owed after the last EOF, and dwords emitted since the last ALIGN pair.
  bit m_in_frame;
  bit m_eof_next;
  int m_syncs_owed;
  int m_since_align;
  int m_align_left;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_frame    = 1'b0;
    m_eof_next    = 1'b0;
    m_syncs_owed  = 0;
    m_since_align = 0;
    m_align_left  = 0;
  endtask

  task automatic step(input logic rst, input logic val, input logic eop,
                      input logic hold, input logic [31:0] dat,
                      output logic a_rdy, output logic [31:0] a_tx,
                      output logic a_k, output logic acc);
    logic        prdy;
    logic [31:0] ptx;
    logic        pk;
    @(negedge clk);
    reset    = rst;
    fis_val  = val;
    fis_eop  = eop;
    hold_req = hold;
    fis_dat  = dat;
    #1;
    a_rdy = fis_rdy;
    prdy  = m_in_frame && !m_eof_next && (m_align_left == 0) && !hold;
    acc   = 1'b0;
    pk    = `DWORD_IS_PRIM;
    ptx   = `SYNC_PRIM;
    if (rst) begin
      model_reset();
    end else if (m_align_left > 0) begin
      ptx = `ALIGN_PRIM;
      m_align_left--;
    end else begin
      if (m_eof_next) begin
        ptx          = `EOF_PRIM;
        m_eof_next   = 1'b0;
        m_in_frame   = 1'b0;
        m_syncs_owed = MIN_SYNC;
      end else if (!m_in_frame) begin
        if (m_syncs_owed > 0) m_syncs_owed--;
        else if (val) begin
          ptx        = `SOF_PRIM;
          m_in_frame = 1'b1;
        end
      end else if (hold) begin
        ptx = `HOLDA_PRIM;
      end else if (val) begin
        ptx = dat;
        pk  = `DWORD_IS_DATA;
        acc = 1'b1;
        if (eop) m_eof_next = 1'b1;
      end else begin
        ptx = `HOLD_PRIM;
      end
`ifdef SATA_FIS_INSERTER_ALIGN_EN
      m_since_align++;
      if (m_since_align == ALIGN_PERIOD) begin
        m_since_align = 0;
        m_align_left  = 2;
      end
`endif
    end
    chk("model_rdy", {32'd0, a_rdy}, {32'd0, prdy});
    @(posedge clk);
    #1;
    a_tx = tx_data;
    a_k  = tx_datak;
    chk("model_tx", {a_k, a_tx}, {pk, ptx});
  endtask

  function automatic void add(input logic v, input logic e, input logic h,
                              input logic [31:0] d, input logic r,
                              input logic [31:0] tx, input logic k);
    vec_t t;
    t.val = v; t.eop = e; t.hold = h; t.dat = d;
    t.exp_rdy = r; t.exp_tx = tx; t.exp_k = k;
    tbl.push_back(t);
  endfunction

  initial begin
    logic        r_o;
    logic [31:0] tx_o;
    logic        k_o;
    logic        acc_o;
    int          n_align;
    logic [32:0] w;

    reset = 1'b1; fis_val = 1'b0; fis_eop = 1'b0; hold_req = 1'b0; fis_dat = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx", {tx_datak, tx_data}, {`DWORD_IS_PRIM, `SYNC_PRIM});
    chk("reset_rdy", {32'd0, fis_rdy}, 33'd0);
    model_reset();

    // Directed vectors: each row's tx is what the following edge loads.
    for (int i = 0; i < 10; i++) add(0, 0, 0, 32'h0, 0, `SYNC_PRIM, `DWORD_IS_PRIM);
    add(1, 0, 0, 32'h11111111, 0, `SOF_PRIM,    `DWORD_IS_PRIM);
    add(1, 0, 0, 32'h11111111, 1, 32'h11111111, `DWORD_IS_DATA);
    add(1, 0, 0, 32'h22222222, 1, 32'h22222222, `DWORD_IS_DATA);
    add(1, 1, 0, 32'h33333333, 1, 32'h33333333, `DWORD_IS_DATA);
    add(0, 0, 0, 32'h0,        0, `EOF_PRIM,    `DWORD_IS_PRIM);
    add(0, 0, 0, 32'h0,        0, `SYNC_PRIM,   `DWORD_IS_PRIM);
    add(0, 0, 0, 32'h0,        0, `SYNC_PRIM,   `DWORD_IS_PRIM);
    add(0, 0, 0, 32'h0,        0, `SYNC_PRIM,   `DWORD_IS_PRIM);
    add(1, 1, 0, 32'hAAAA5555, 0, `SOF_PRIM,    `DWORD_IS_PRIM);
    add(1, 1, 0, 32'hAAAA5555, 1, 32'hAAAA5555, `DWORD_IS_DATA);
    add(1, 1, 0, 32'h0F0F0F0F, 0, `EOF_PRIM,    `DWORD_IS_PRIM);
    add(1, 1, 0, 32'h0F0F0F0F, 0, `SYNC_PRIM,   `DWORD_IS_PRIM);
    add(1, 1, 0, 32'h0F0F0F0F, 0, `SYNC_PRIM,   `DWORD_IS_PRIM);
    add(1, 1, 0, 32'h0F0F0F0F, 0, `SOF_PRIM,    `DWORD_IS_PRIM);
    add(1, 1, 0, 32'h0F0F0F0F, 1, 32'h0F0F0F0F, `DWORD_IS_DATA);
    add(0, 1, 0, 32'h0,        0, `EOF_PRIM,    `DWORD_IS_PRIM);
    add(0, 0, 0, 32'h0,        0, `SYNC_PRIM,   `DWORD_IS_PRIM);
    add(0, 0, 0, 32'h0,        0, `SYNC_PRIM,   `DWORD_IS_PRIM);
    add(1, 0, 0, 32'h00000001, 0, `SOF_PRIM,    `DWORD_IS_PRIM);
    add(1, 0, 0, 32'h00000001, 1, 32'h00000001, `DWORD_IS_DATA);
    add(0, 0, 0, 32'h0,        1, `HOLD_PRIM,   `DWORD_IS_PRIM);
    add(0, 1, 0, 32'h0,        1, `HOLD_PRIM,   `DWORD_IS_PRIM);
    add(0, 0, 0, 32'h0,        1, `HOLD_PRIM,   `DWORD_IS_PRIM);
    add(1, 1, 0, 32'h00000002, 1, 32'h00000002, `DWORD_IS_DATA);
    add(0, 0, 0, 32'h0,        0, `EOF_PRIM,    `DWORD_IS_PRIM);
    add(0, 0, 1, 32'h0,        0, `SYNC_PRIM,   `DWORD_IS_PRIM);
    add(0, 0, 0, 32'h0,        0, `SYNC_PRIM,   `DWORD_IS_PRIM);
    add(1, 0, 1, 32'h0000000A, 0, `SOF_PRIM,    `DWORD_IS_PRIM);
    add(1, 0, 0, 32'h0000000A, 1, 32'h0000000A, `DWORD_IS_DATA);
    add(1, 0, 1, 32'h0000000B, 0, `HOLDA_PRIM,  `DWORD_IS_PRIM);
    add(1, 0, 1, 32'h0000000B, 0, `HOLDA_PRIM,  `DWORD_IS_PRIM);
    add(1, 0, 0, 32'h0000000B, 1, 32'h0000000B, `DWORD_IS_DATA);
    add(1, 1, 0, 32'h0000000C, 1, 32'h0000000C, `DWORD_IS_DATA);
    add(0, 0, 1, 32'h0,        0, `EOF_PRIM,    `DWORD_IS_PRIM);
    add(0, 0, 0, 32'h0,        0, `SYNC_PRIM,   `DWORD_IS_PRIM);
    add(0, 0, 0, 32'h0,        0, `SYNC_PRIM,   `DWORD_IS_PRIM);

    foreach (tbl[i]) begin
      step(1'b0, tbl[i].val, tbl[i].eop, tbl[i].hold, tbl[i].dat, r_o, tx_o, k_o, acc_o);
`ifndef SATA_FIS_INSERTER_ALIGN_EN
      chk($sformatf("tbl%0d_rdy", i), {32'd0, r_o}, {32'd0, tbl[i].exp_rdy});
      chk($sformatf("tbl%0d_tx", i), {k_o, tx_o}, {tbl[i].exp_k, tbl[i].exp_tx});
`endif
    end

    // Reset in the middle of a frame abandons it; the next frame starts clean.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h00000005, r_o, tx_o, k_o, acc_o);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h00000005, r_o, tx_o, k_o, acc_o);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h00000006, r_o, tx_o, k_o, acc_o);
    chk("rst_mid_tx", {k_o, tx_o}, {`DWORD_IS_PRIM, `SYNC_PRIM});
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h00000007, r_o, tx_o, k_o, acc_o);
    chk("rst_mid_rdy", {32'd0, r_o}, 33'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h00000007, r_o, tx_o, k_o, acc_o);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, r_o, tx_o, k_o, acc_o);

    // Continuous 20-dword frame (exercises ALIGN insertion when enabled).
    for (int i = 0; i < 20; i++) src_q.push_back({(i == 19), 32'hC0DE0000 + 32'(i)});
    n_align = 0;
    for (int c = 0; c < 80 && src_q.size() > 0; c++) begin
      w = src_q[0];
      step(1'b0, 1'b1, w[32], 1'b0, w[31:0], r_o, tx_o, k_o, acc_o);
      if (acc_o) void'(src_q.pop_front());
      if (tx_o == `ALIGN_PRIM) n_align++;
    end
    chk("long_drained", 33'(src_q.size()), 33'd0);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, r_o, tx_o, k_o, acc_o);
      if (tx_o == `ALIGN_PRIM) n_align++;
    end
`ifndef SATA_FIS_INSERTER_ALIGN_EN
    chk("no_align", 33'(n_align), 33'd0);
`endif

    // Randomized traffic: random frame lengths, bubbles and HOLD bursts.
    src_q.delete();
    for (int c = 0; c < 1500; c++) begin
      logic v;
      logic h;
      logic [31:0] d;
      logic e;
      if (src_q.size() == 0) begin
        int len;
        len = int'($urandom_range(1, 6));
        for (int k = 0; k < len; k++) src_q.push_back({(k == len - 1), $urandom()});
      end
      v = ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 5) == 0);
      if (v) begin
        w = src_q[0];
        d = w[31:0];
        e = w[32];
      end else begin
        d = $urandom();
        e = 1'($urandom_range(0, 1));
      end
      step(1'b0, v, e, h, d, r_o, tx_o, k_o, acc_o);
      if (acc_o) void'(src_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
